// File: rtl/dff_bank_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dff_bank_wr_arbiter_pkg
// Shared definitions for the register-bank write arbiter:
//   - state_e     : arbiter FSM states (ARB = arbitrate, WR = write cycle)
//   - *_DEF       : default parameter values for the arbiter
//   - rr_next()   : round-robin winner search starting after the last winner
// ---------------------------------------------------------------------------
package dff_bank_wr_arbiter_pkg;

  typedef enum logic {
    ARB = 1'b0,
    WR  = 1'b1
  } state_e;

  localparam int NREQ_DEF = 4;
  localparam int NREG_DEF = 8;
  localparam int DW_DEF   = 8;
  localparam int AW_DEF   = 3;
  localparam int IW_DEF   = 2;

  // The helper works on a fixed maximum requester count; callers zero-pad.
  localparam int RR_MAX   = 8;
  localparam int RR_IDX_W = 3;

  // Returns the first requester with its bit set, searching upward from
  // (last + 1) mod n with wrap. Returns 'last' when nothing is requesting;
  // the caller only uses the result when at least one request is present.
  function automatic logic [RR_IDX_W-1:0] rr_next(
    input logic [RR_MAX-1:0]   req,
    input logic [RR_IDX_W-1:0] last,
    input int                  n
  );
    logic [RR_IDX_W-1:0] pick;
    logic [RR_IDX_W-1:0] sel;
    int                  idx;
    pick = last;
    // Walk from the farthest candidate to the nearest so the nearest hit
    // overwrites any earlier one and ends up as the winner.
    for (int k = RR_MAX; k >= 1; k--) begin
      if (k <= n) begin
        idx = (int'(last) + k) % n;
        sel = idx[RR_IDX_W-1:0];
        if (req[sel]) begin
          pick = sel;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dff_bank_wr_arbiter_reg.sv
// ---------------------------------------------------------------------------
// dff_bank_reg
// One DW-bit storage register of the bank, loaded when en_i is high.
// Ports:
//   CLK  - clock, rising edge
//   RST  - asynchronous active-high reset, clears the register to 0
//   en_i - load enable
//   d_i  - data to load
//   q_o  - register contents
// ---------------------------------------------------------------------------
module dff_bank_reg #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          en_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);

  logic [DW-1:0] val_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      val_q <= '0;
    end else if (en_i) begin
      val_q <= d_i;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/dff_bank_wr_arbiter.sv
// ---------------------------------------------------------------------------
// dff_bank_wr_arbiter
// Round-robin arbiter sharing one write path into a bank of NREG DW-bit
// registers among NREQ requesters using a level REQ / one-cycle ACK
// handshake. Each grant takes two cycles: ARB (pick and latch) then WR
// (write the bank, acknowledge the winner).
// Ports:
//   CLK      - clock, rising edge
//   RST      - asynchronous active-high reset
//   REQ      - per-requester write request (level)
//   REQ_ADDR - packed addresses, requester i at [i*AW +: AW]
//   REQ_DATA - packed data, requester i at [i*DW +: DW]
//   ACK      - one-hot write acknowledge, high during WR
//   GNT_ID   - index of the current or most recent winner
//   BUSY     - high during WR
//   ERR      - high during WR when the latched address is >= NREG
//   BANK_Q   - packed register contents, register r at [r*DW +: DW]
// ---------------------------------------------------------------------------
module dff_bank_wr_arbiter
  import dff_bank_wr_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF,
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int IW   = IW_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  input  logic [NREQ*DW-1:0] REQ_DATA,
  output logic [NREQ-1:0]    ACK,
  output logic [IW-1:0]      GNT_ID,
  output logic               BUSY,
  output logic               ERR,
  output logic [NREG*DW-1:0] BANK_Q
);

  localparam logic [AW:0] NREG_LIM = (AW+1)'(NREG);

  state_e         state_q;
  logic [IW-1:0]  win_q;
  logic [IW-1:0]  last_q;
  logic [IW-1:0]  gnt_q;
  logic [AW-1:0]  addr_q;
  logic [DW-1:0]  data_q;

  logic [RR_MAX-1:0] req_ext;
  logic [IW-1:0]     pick_d;
  logic              any_req;
  logic [AW-1:0]     req_addr_a [NREQ];
  logic [DW-1:0]     req_data_a [NREQ];
  logic [NREG-1:0]   bank_en;

  // Unpack the requester buses so the winner's fields can be muxed by index.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_addr_a[gi] = REQ_ADDR[gi*AW +: AW];
    assign req_data_a[gi] = REQ_DATA[gi*DW +: DW];
  end

  always_comb begin
    req_ext = '0;
    req_ext[NREQ-1:0] = REQ;
  end

  assign any_req = |REQ;
  assign pick_d  = IW'(rr_next(req_ext, RR_IDX_W'(last_q), NREQ));

  // Arbiter FSM. ARB latches the winner and its write; WR lasts one cycle
  // and moves the round-robin pointer past the winner.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ARB;
      win_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      // Pointer at the last index makes requester 0 the first candidate.
      last_q  <= IW'(NREQ - 1);
    end else begin
      case (state_q)
        ARB: begin
          if (any_req) begin
            win_q   <= pick_d;
            gnt_q   <= pick_d;
            addr_q  <= req_addr_a[pick_d];
            data_q  <= req_data_a[pick_d];
            state_q <= WR;
          end
        end
        WR: begin
          last_q  <= win_q;
          state_q <= ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

  // Handshake outputs decode only registered state, so REQ never reaches
  // ACK/BUSY/ERR combinationally; an async reset drops them immediately.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_ack
    assign ACK[gi] = (state_q == WR) && (win_q == IW'(gi));
  end

  assign BUSY   = (state_q == WR);
  assign ERR    = (state_q == WR) && ({1'b0, addr_q} >= NREG_LIM);
  assign GNT_ID = gnt_q;

  // Out-of-range addresses match no register, so the enables stay one-hot
  // or all zero.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_bank
    assign bank_en[gi] = (state_q == WR) && (addr_q == AW'(gi));

    dff_bank_reg #(
      .DW(DW)
    ) u_reg (
      .CLK  (CLK),
      .RST  (RST),
      .en_i (bank_en[gi]),
      .d_i  (data_q),
      .q_o  (BANK_Q[gi*DW +: DW])
    );
  end

endmodule

// File: tb/tb_dff_bank_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dff_bank_wr_arbiter
// Directed bench for dff_bank_wr_arbiter with a 6-register bank so that
// address 7 exercises the out-of-range path. Inputs change 1 time unit
// after a rising edge, and outputs are checked at that same point.
// ---------------------------------------------------------------------------
module tb_dff_bank_wr_arbiter;

  localparam int NREQ = 4;
  localparam int NREG = 6;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int IW   = 2;

  logic               CLK;
  logic               RST;
  logic [NREQ-1:0]    REQ;
  logic [NREQ*AW-1:0] REQ_ADDR;
  logic [NREQ*DW-1:0] REQ_DATA;
  logic [NREQ-1:0]    ACK;
  logic [IW-1:0]      GNT_ID;
  logic               BUSY;
  logic               ERR;
  logic [NREG*DW-1:0] BANK_Q;

  logic [NREG*DW-1:0] exp_bank;
  int n_checks;
  int n_fail;

  dff_bank_wr_arbiter #(
    .NREQ(NREQ), .NREG(NREG), .DW(DW), .AW(AW), .IW(IW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .REQ      (REQ),
    .REQ_ADDR (REQ_ADDR),
    .REQ_DATA (REQ_DATA),
    .ACK      (ACK),
    .GNT_ID   (GNT_ID),
    .BUSY     (BUSY),
    .ERR      (ERR),
    .BANK_Q   (BANK_Q)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    REQ_ADDR[idx*AW +: AW] = a;
    REQ_DATA[idx*DW +: DW] = d;
  endtask

  task automatic set_exp(input int r, input logic [DW-1:0] d);
    exp_bank[r*DW +: DW] = d;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_bank = '0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    REQ      = '0;
    REQ_ADDR = '0;
    REQ_DATA = '0;
    exp_bank = '0;

    // Reset state
    tick();
    check_eq("rst_ack",  64'(ACK),    64'h0);
    check_eq("rst_busy", 64'(BUSY),   64'h0);
    check_eq("rst_err",  64'(ERR),    64'h0);
    check_eq("rst_gnt",  64'(GNT_ID), 64'h0);
    check_eq("rst_bank", 64'(BANK_Q), 64'h0);
    RST = 1'b0;

    // Single request: requester 0 writes A5 to register 3
    set_req(0, 3'd3, 8'hA5);
    REQ = 4'b0001;
    tick();
    check_eq("t1_ack",  64'(ACK),    64'h1);
    check_eq("t1_busy", 64'(BUSY),   64'h1);
    check_eq("t1_gnt",  64'(GNT_ID), 64'h0);
    tick();
    REQ = '0;
    set_exp(3, 8'hA5);
    check_eq("t1_bank",     64'(BANK_Q), 64'(exp_bank));
    check_eq("t1_ack_done", 64'(ACK),    64'h0);
    check_eq("t1_busy_done",64'(BUSY),   64'h0);

    // All four requesting from reset: grants 0,1,2,3 two cycles apart
    pulse_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), 8'h10 + 8'(i));
    REQ = 4'b1111;
    for (int g = 0; g < NREQ; g++) begin
      tick();
      check_eq($sformatf("t2_ack%0d", g), 64'(ACK),    64'(4'b0001 << g));
      check_eq($sformatf("t2_gnt%0d", g), 64'(GNT_ID), 64'(g));
      tick();
      REQ[g] = 1'b0;
      set_exp(g, 8'h10 + 8'(g));
    end
    check_eq("t2_bank", 64'(BANK_Q), 64'(exp_bank));

    // Rotation: make 2 the last winner, then REQ=0101 -> 0 then 2
    set_req(2, 3'd4, 8'h24);
    REQ = 4'b0100;
    tick();
    check_eq("t3_pre_gnt", 64'(GNT_ID), 64'h2);
    tick();
    REQ = '0;
    set_exp(4, 8'h24);
    set_req(0, 3'd5, 8'h50);
    set_req(2, 3'd1, 8'h21);
    REQ = 4'b0101;
    tick();
    check_eq("t3_gnt_a", 64'(GNT_ID), 64'h0);
    check_eq("t3_ack_a", 64'(ACK),    64'h1);
    tick();
    REQ[0] = 1'b0;
    set_exp(5, 8'h50);
    tick();
    check_eq("t3_gnt_b", 64'(GNT_ID), 64'h2);
    check_eq("t3_ack_b", 64'(ACK),    64'h4);
    tick();
    REQ = '0;
    set_exp(1, 8'h21);
    check_eq("t3_bank", 64'(BANK_Q), 64'(exp_bank));

    // Out-of-range write: address 7 with a 6-register bank
    set_req(1, 3'd7, 8'hFF);
    REQ = 4'b0010;
    tick();
    check_eq("t4_ack", 64'(ACK),    64'h2);
    check_eq("t4_err", 64'(ERR),    64'h1);
    check_eq("t4_gnt", 64'(GNT_ID), 64'h1);
    tick();
    REQ = '0;
    check_eq("t4_err_done", 64'(ERR),    64'h0);
    check_eq("t4_bank",     64'(BANK_Q), 64'(exp_bank));

    // Reset during WR to address 5: write dropped, outputs cleared at once
    set_req(3, 3'd5, 8'h77);
    REQ = 4'b1000;
    tick();
    check_eq("t5_ack_wr", 64'(ACK), 64'h8);
    #2;
    RST = 1'b1;
    #1;
    exp_bank = '0;
    check_eq("t5_ack",  64'(ACK),    64'h0);
    check_eq("t5_busy", 64'(BUSY),   64'h0);
    check_eq("t5_gnt",  64'(GNT_ID), 64'h0);
    check_eq("t5_bank", 64'(BANK_Q), 64'(exp_bank));
    REQ = '0;
    tick();
    RST = 1'b0;
    tick();
    check_eq("t5_bank_after", 64'(BANK_Q), 64'(exp_bank));

    // Idle: one write first so stability is meaningful, then 20 quiet cycles
    set_req(0, 3'd2, 8'h3C);
    REQ = 4'b0001;
    tick();
    tick();
    REQ = '0;
    set_exp(2, 8'h3C);
    for (int c = 0; c < 20; c++) begin
      tick();
      check_eq($sformatf("t6_ack%0d", c),  64'(ACK),    64'h0);
      check_eq($sformatf("t6_busy%0d", c), 64'(BUSY),   64'h0);
      check_eq($sformatf("t6_bank%0d", c), 64'(BANK_Q), 64'(exp_bank));
    end
    check_eq("t6_gnt_hold", 64'(GNT_ID), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
